// File: rtl/ppr_pkg.sv
// Shared definitions for the PPR score datapath: default widths and the
// encoding of the per-engine read-modify-write lock.
package ppr_pkg;

    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/score_bram_scheduler_rr_arbiter.sv
// Round-robin pick over NUM_ENG eligible bits; the pointer advances past
// each winner and holds when nothing is eligible.
module rr_arbiter #(
    parameter int NUM_ENG = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ENG-1:0] elig,
    output logic [NUM_ENG-1:0] winner,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_ENG) begin
                idx = idx - NUM_ENG;
            end
            if (!win_vld && elig[idx]) begin
                win_vld     = 1'b1;
                win_idx     = IDX_W'(idx);
                winner[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (win_vld) begin
            rr_ptr <= (win_idx == IDX_W'(NUM_ENG - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/score_bram_scheduler.sv
// Arbitrates diffusion engines onto one single-port score BRAM, holding
// per-engine address locks across read-modify-write so neighbour updates merge.
module score_bram_scheduler
    import ppr_pkg::*;
#(
    parameter int NUM_ENG    = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ENG-1:0]            req,
    input  logic [NUM_ENG-1:0]            lock,
    input  logic [NUM_ENG-1:0]            we,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] wdata,
    output logic [NUM_ENG-1:0]            gnt,
    output logic [NUM_ENG-1:0]            conflict,
    output logic [NUM_ENG-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_wdata,
    input  logic [DATA_WIDTH-1:0]         bram_rdata,
    output logic [CNT_WIDTH-1:0]          conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_ENG);
    localparam int SUM_W = CNT_WIDTH + IDX_W + 1;

    lock_state_t           lock_st   [NUM_ENG];
    logic [ADDR_WIDTH-1:0] lock_addr [NUM_ENG];

    logic [NUM_ENG-1:0]    blocked;
    logic [NUM_ENG-1:0]    elig;
    logic [NUM_ENG-1:0]    winner;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_vld;
    logic                  win_we;
    logic                  win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [IDX_W:0]        n_blk;
    logic [NUM_ENG-1:0]    rd_vld_p1;
    logic [DATA_WIDTH-1:0] rdata_hold;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [IDX_W:0]       inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
            return {CNT_WIDTH{1'b1}};
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // An engine is held off by any other engine's live lock on its address
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            for (int j = 0; j < NUM_ENG; j++) begin
                if (j != i && lock_st[j] == LOCK_HELD &&
                    lock_addr[j] == addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign elig = req & ~gnt & ~blocked;

    always_comb begin
        n_blk = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            n_blk = n_blk + (IDX_W + 1)'(req[i] & blocked[i]);
        end
    end

    rr_arbiter #(
        .NUM_ENG (NUM_ENG),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .elig    (elig),
        .winner  (winner),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign win_we    = we[win_idx];
    assign win_lock  = lock[win_idx];
    assign win_addr  = addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Stage p1: grant and BRAM command registered one cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            bram_en      <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
            rd_vld_p1    <= '0;
            conflict     <= '0;
            conflict_cnt <= '0;
        end else begin
            gnt          <= winner;
            bram_en      <= win_vld;
            bram_we      <= win_vld & win_we;
            rd_vld_p1    <= winner & {NUM_ENG{~win_we}};
            conflict     <= req & blocked;
            conflict_cnt <= sat_add(conflict_cnt, n_blk);
            if (win_vld) begin
                bram_addr  <= win_addr;
                bram_wdata <= win_wdata;
            end
        end
    end

    // Lock changes land on the grant edge so the next arbitration already sees them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                lock_st[i] <= LOCK_FREE;
            end
        end else if (win_vld) begin
            if (!win_we && win_lock) begin
                lock_st[win_idx] <= LOCK_HELD;
            end else if (win_we && lock_st[win_idx] == LOCK_HELD &&
                         lock_addr[win_idx] == win_addr) begin
                lock_st[win_idx] <= LOCK_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (win_vld && !win_we && win_lock) begin
            lock_addr[win_idx] <= win_addr;
        end
    end

    // Stage p2: BRAM output is live; rdata passes it through and keeps it afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid     <= '0;
            rdata_hold <= '0;
        end else begin
            rvalid <= rd_vld_p1;
            if (|rvalid) begin
                rdata_hold <= bram_rdata;
            end
        end
    end

    assign rdata = (|rvalid) ? bram_rdata : rdata_hold;

endmodule

// File: tb/tb_score_bram_scheduler.sv
// Bench for score_bram_scheduler: BRAM model, read scoreboard keyed by
// expected completion cycle, and directed arbitration/lock sequences.
module tb_score_bram_scheduler;

    localparam int NE = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NE-1:0]    req, lock, we;
    logic [NE*AW-1:0] addr;
    logic [NE*DW-1:0] wdata;
    logic [NE-1:0]    gnt, conflict, rvalid;
    logic [DW-1:0]    rdata;
    logic             bram_en, bram_we;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_wdata;
    logic [DW-1:0]    bram_rdata;
    logic [CW-1:0]    conflict_cnt;

    always #5 clk = ~clk;

    score_bram_scheduler #(
        .NUM_ENG    (NE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .conflict     (conflict),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .bram_rdata   (bram_rdata),
        .conflict_cnt (conflict_cnt)
    );

    function automatic logic [DW-1:0] init_val(int a);
        return (a == 5) ? 32'h40 : (32'h5000_0000 | DW'(a));
    endfunction

    // Single-port BRAM, one-cycle registered read
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    bit            bram_wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bram_mem[bram_addr] <= bram_wdata;
                bram_wr[bram_addr]  <= 1'b1;
            end else begin
                bram_rdata <= bram_wr[bram_addr] ? bram_mem[bram_addr] : init_val(int'(bram_addr));
            end
        end
    end

    typedef struct {
        int            eng;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t       sb [$];
    logic [DW-1:0] exp_mem [int];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc_cnt = 0;

    function automatic logic [DW-1:0] exp_rd(int a);
        return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_cnt);
        end
    endtask

    task automatic monitor();
        if (sb.size() != 0 && sb[0].due == cyc_cnt) begin
            chk("rvalid", 64'(rvalid), 64'(NE'(1) << sb[0].eng));
            chk("rdata", 64'(rdata), 64'(sb[0].data));
            void'(sb.pop_front());
        end else begin
            chk("rvalid_idle", 64'(rvalid), 64'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
        monitor();
    endtask

    task automatic drive(input int e, input logic r, input logic l, input logic w,
                         input int a, input logic [DW-1:0] d);
        req[e]            = r;
        lock[e]           = l;
        we[e]             = w;
        addr[e*AW +: AW]  = AW'(a);
        wdata[e*DW +: DW] = d;
    endtask

    task automatic push_rd(input int e, input int a, input int due);
        sb.push_back('{e, exp_rd(a), due});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_conflict", 64'(conflict), 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_bram_we", 64'(bram_we), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_bram_wdata", 64'(bram_wdata), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);

        // Single read of address 5
        drive(0, 1'b1, 1'b0, 1'b0, 5, '0);
        push_rd(0, 5, cyc_cnt + 2);
        cyc();
        chk("single_gnt", 64'(gnt), 64'b0001);
        chk("single_en", 64'(bram_en), 64'd1);
        chk("single_we", 64'(bram_we), 64'd0);
        chk("single_addr", 64'(bram_addr), 64'd5);
        drive(0, 1'b0, 1'b0, 1'b0, 5, '0);
        cyc();
        cyc();
        chk("rdata_hold", 64'(rdata), 64'h40);

        // Round-robin with all engines requesting continuously
        do_reset();
        for (int e = 0; e < NE; e++) drive(e, 1'b1, 1'b0, 1'b0, 20 + e, '0);
        begin
            int base;
            base = cyc_cnt;
            for (int k = 0; k < 8; k++) push_rd(k % NE, 20 + (k % NE), base + 2 + k);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rr_gnt", 64'(gnt), 64'(NE'(1) << (k % NE)));
            if (k == 7) req = '0;
        end
        cyc();
        chk("rr_idle_gnt", 64'(gnt), 64'd0);
        cyc();

        // RMW lock: engine 1 locks 9, engine 2 waits for the write-back
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b0, 9, '0);
        push_rd(1, 9, cyc_cnt + 2);
        cyc();
        chk("lock_rd_gnt", 64'(gnt), 64'b0010);
        drive(1, 1'b0, 1'b0, 1'b0, 9, '0);
        drive(2, 1'b1, 1'b0, 1'b0, 9, '0);
        for (int m = 1; m <= 3; m++) begin
            cyc();
            chk("lock_conflict", 64'(conflict), 64'b0100);
            chk("lock_nogrant", 64'(gnt), 64'd0);
            chk("lock_cnt", 64'(conflict_cnt), 64'(m));
        end
        drive(1, 1'b1, 1'b0, 1'b1, 9, 32'hABCD_0009);
        exp_mem[9] = 32'hABCD_0009;
        cyc();
        chk("wb_gnt", 64'(gnt), 64'b0010);
        chk("wb_we", 64'(bram_we), 64'd1);
        chk("wb_addr", 64'(bram_addr), 64'd9);
        chk("wb_wdata", 64'(bram_wdata), 64'hABCD_0009);
        chk("wb_conflict", 64'(conflict), 64'b0100);
        drive(1, 1'b0, 1'b0, 1'b0, 9, '0);
        push_rd(2, 9, cyc_cnt + 2);
        cyc();
        chk("unlock_gnt", 64'(gnt), 64'b0100);
        chk("unlock_conflict", 64'(conflict), 64'd0);
        chk("unlock_cnt", 64'(conflict_cnt), 64'd4);
        drive(2, 1'b0, 1'b0, 1'b0, 9, '0);
        cyc();

        // Non-matching address passes a held lock; then saturate the counter
        drive(1, 1'b1, 1'b1, 1'b0, 9, '0);
        push_rd(1, 9, cyc_cnt + 2);
        cyc();
        chk("relock_gnt", 64'(gnt), 64'b0010);
        drive(1, 1'b0, 1'b0, 1'b0, 9, '0);
        drive(2, 1'b1, 1'b0, 1'b0, 10, '0);
        push_rd(2, 10, cyc_cnt + 2);
        cyc();
        chk("nomatch_gnt", 64'(gnt), 64'b0100);
        chk("nomatch_conflict", 64'(conflict), 64'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 10, '0);
        drive(3, 1'b1, 1'b0, 1'b0, 9, '0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 5) chk("sat_mid_cnt", 64'(conflict_cnt), 64'd10);
        end
        chk("sat_cnt", 64'(conflict_cnt), 64'd15);
        chk("sat_conflict", 64'(conflict), 64'b1000);
        chk("sat_nogrant", 64'(gnt), 64'd0);
        cyc();
        cyc();
        chk("sat_hold", 64'(conflict_cnt), 64'd15);
        drive(3, 1'b0, 1'b0, 1'b0, 9, '0);
        cyc();

        // Reset between grant and read data
        drive(2, 1'b1, 1'b0, 1'b0, 10, '0);
        cyc();
        chk("mid_gnt", 64'(gnt), 64'b0100);
        rst = 1'b1;
        drive(2, 1'b0, 1'b0, 1'b0, 10, '0);
        cyc();
        rst = 1'b0;
        chk("mid_rvalid", 64'(rvalid), 64'd0);
        chk("mid_cnt", 64'(conflict_cnt), 64'd0);
        chk("mid_bram_en", 64'(bram_en), 64'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 30, '0);
        drive(3, 1'b1, 1'b0, 1'b0, 9, '0);
        push_rd(0, 30, cyc_cnt + 2);
        push_rd(3, 9, cyc_cnt + 3);
        cyc();
        chk("post_rst_gnt0", 64'(gnt), 64'b0001);
        chk("post_rst_conflict", 64'(conflict), 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 30, '0);
        cyc();
        chk("post_rst_gnt3", 64'(gnt), 64'b1000);
        chk("post_rst_unlocked", 64'(conflict), 64'd0);
        drive(3, 1'b0, 1'b0, 1'b0, 9, '0);
        cyc();
        cyc();
        cyc();
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
